// File: rtl/mem_router.sv
// Address-decoding router: fans requests out to NUM_PORTS slaves and
// returns read data strictly in request order via a small index queue.
module mem_router #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_WIDTH = 32,
    parameter int LOW_ADDR_WIDTH = 28,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [DATA_WIDTH-1:0] DUMMY_DATA = '0,
    localparam int BE_WIDTH = DATA_WIDTH / 8,
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    output logic                            ready,
    input  logic [LOW_ADDR_WIDTH+3:0]       addr,
    input  logic [DATA_WIDTH-1:0]           write_data,
    input  logic [BE_WIDTH-1:0]             byte_enable,
    input  logic                            write_req,
    input  logic                            read_req,
    output logic [DATA_WIDTH-1:0]           read_data,
    output logic                            read_data_valid,
    output logic [CNT_WIDTH-1:0]            outstanding,
    output logic                            order_error,
    output logic [LOW_ADDR_WIDTH-1:0]       port_addr,
    output logic [DATA_WIDTH-1:0]           port_write_data,
    output logic [BE_WIDTH-1:0]             port_byte_enable,
    output logic [NUM_PORTS-1:0]            port_write_req,
    output logic [NUM_PORTS-1:0]            port_read_req,
    input  logic [NUM_PORTS-1:0]            port_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_read_data,
    input  logic [NUM_PORTS-1:0]            port_read_data_valid
);

    localparam logic [3:0] UNMAPPED = 4'hF;
    localparam int PTR_WIDTH = $clog2(MAX_OUTSTANDING);

    logic [3:0]           sel;
    logic [3:0]           target;
    logic                 mapped;
    logic                 slot_ready;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 stray;
    logic [3:0]           push_code;
    logic [3:0]           head;
    logic                 head_mapped;
    logic [3:0]           queue [MAX_OUTSTANDING];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count;

    assign sel = addr[LOW_ADDR_WIDTH+3 -: 4];
    assign mapped = (sel != 4'd0) && (sel <= 4'(NUM_PORTS));
    assign target = sel - 4'd1;

    assign port_addr = addr[LOW_ADDR_WIDTH-1:0];
    assign port_write_data = write_data;
    assign port_byte_enable = byte_enable;

    assign full = (count == CNT_WIDTH'(MAX_OUTSTANDING));
    assign empty = (count == '0);
    assign outstanding = count;

    always_comb begin
        slot_ready = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (mapped && target == 4'(i)) begin
                slot_ready = port_ready[i];
            end
        end
    end

    // Full queue blocks acceptance even when a pop frees a slot this cycle.
    assign ready = slot_ready && !full;
    assign push = read_req && !write_req && ready;
    assign push_code = mapped ? target : UNMAPPED;

    always_comb begin
        port_write_req = '0;
        port_read_req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (mapped && target == 4'(i)) begin
                port_write_req[i] = write_req && ready;
                port_read_req[i] = read_req && !write_req && ready;
            end
        end
    end

    assign head = queue[rd_ptr];
    assign head_mapped = (head != UNMAPPED);

    always_comb begin
        pop = 1'b0;
        stray = 1'b0;
        read_data = '0;
        if (!empty && !head_mapped) begin
            pop = 1'b1;
            read_data = DUMMY_DATA;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_read_data_valid[i]) begin
                if (!empty && head_mapped && head == 4'(i)) begin
                    pop = 1'b1;
                    read_data = port_read_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    stray = 1'b1;
                end
            end
        end
    end

    assign read_data_valid = pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            order_error <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                queue[i] <= UNMAPPED;
            end
        end else begin
            if (push) begin
                queue[wr_ptr] <= push_code;
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
            if (stray) begin
                order_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: decode, in-order returns, full queue,
// write/read collision, unmapped region and reset behaviour.
module tb_mem_router;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        write_req;
    logic        read_req;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic [2:0]  outstanding;
    logic        order_error;
    logic [27:0] port_addr;
    logic [31:0] port_write_data;
    logic [3:0]  port_byte_enable;
    logic [1:0]  port_write_req;
    logic [1:0]  port_read_req;
    logic [1:0]  port_ready;
    logic [63:0] port_read_data;
    logic [1:0]  port_read_data_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_router #(
        .NUM_PORTS(2),
        .DATA_WIDTH(32),
        .LOW_ADDR_WIDTH(28),
        .MAX_OUTSTANDING(4),
        .DUMMY_DATA(32'hBADC_0FFE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ready(ready),
        .addr(addr),
        .write_data(write_data),
        .byte_enable(byte_enable),
        .write_req(write_req),
        .read_req(read_req),
        .read_data(read_data),
        .read_data_valid(read_data_valid),
        .outstanding(outstanding),
        .order_error(order_error),
        .port_addr(port_addr),
        .port_write_data(port_write_data),
        .port_byte_enable(port_byte_enable),
        .port_write_req(port_write_req),
        .port_read_req(port_read_req),
        .port_ready(port_ready),
        .port_read_data(port_read_data),
        .port_read_data_valid(port_read_data_valid)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_req = 1'b0;
        read_req = 1'b0;
        port_read_data_valid = 2'b00;
        port_read_data = '0;
    endtask

    task automatic respond(input int p, input logic [31:0] d);
        port_read_data = '0;
        port_read_data[p*32 +: 32] = d;
        port_read_data_valid = 2'b00;
        port_read_data_valid[p] = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        addr = '0;
        write_data = '0;
        byte_enable = '0;
        port_ready = 2'b11;
        idle();
        #12;
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_order_error", 32'(order_error), 32'd0);
        check("rst_rdv", 32'(read_data_valid), 32'd0);
        check("rst_rdata", read_data, 32'd0);
        reset_n = 1'b1;
        step();

        // single read to port0, returned 3 cycles later
        addr = 32'h1000_0010;
        read_req = 1'b1;
        #1;
        check("rd0_ready", 32'(ready), 32'd1);
        check("rd0_port_rreq", 32'(port_read_req), 32'd1);
        check("rd0_port_addr", 32'(port_addr), 32'h0000_0010);
        step();
        idle();
        #1;
        check("rd0_outst1", 32'(outstanding), 32'd1);
        check("rd0_rdv_wait", 32'(read_data_valid), 32'd0);
        step();
        step();
        respond(0, 32'hDEAD_BEEF);
        #1;
        check("rd0_rdv", 32'(read_data_valid), 32'd1);
        check("rd0_rdata", read_data, 32'hDEAD_BEEF);
        step();
        idle();
        #1;
        check("rd0_outst0", 32'(outstanding), 32'd0);
        check("rd0_rdv_off", 32'(read_data_valid), 32'd0);
        check("rd0_no_err", 32'(order_error), 32'd0);

        // write and read together: write wins
        addr = 32'h2000_0004;
        write_data = 32'h1234_5678;
        byte_enable = 4'b1010;
        write_req = 1'b1;
        read_req = 1'b1;
        #1;
        check("wr_rd_wreq", 32'(port_write_req), 32'b10);
        check("wr_rd_rreq", 32'(port_read_req), 32'b00);
        check("wr_rd_wdata", port_write_data, 32'h1234_5678);
        check("wr_rd_be", 32'(port_byte_enable), 32'b1010);
        step();
        idle();
        #1;
        check("wr_rd_outst", 32'(outstanding), 32'd0);

        // port not ready stalls the request
        port_ready = 2'b10;
        addr = 32'h1000_0000;
        read_req = 1'b1;
        #1;
        check("nrdy_ready", 32'(ready), 32'd0);
        check("nrdy_rreq", 32'(port_read_req), 32'd0);
        step();
        idle();
        port_ready = 2'b11;
        #1;
        check("nrdy_outst", 32'(outstanding), 32'd0);

        // unmapped reads (sel 0xF and sel 3) return dummy data next cycle
        addr = 32'hF000_0000;
        read_req = 1'b1;
        #1;
        check("unm_ready", 32'(ready), 32'd1);
        check("unm_rreq", 32'(port_read_req), 32'd0);
        step();
        addr = 32'h3000_0000;
        #1;
        check("unm_rdv", 32'(read_data_valid), 32'd1);
        check("unm_rdata", read_data, 32'hBADC_0FFE);
        check("unm_outst", 32'(outstanding), 32'd1);
        step();
        idle();
        #1;
        check("unm3_rdv", 32'(read_data_valid), 32'd1);
        check("unm3_rdata", read_data, 32'hBADC_0FFE);
        step();
        #1;
        check("unm_drained", 32'(outstanding), 32'd0);
        check("unm_rdv_off", 32'(read_data_valid), 32'd0);
        addr = 32'hF000_0000;
        write_req = 1'b1;
        #1;
        check("unm_wr_ready", 32'(ready), 32'd1);
        check("unm_wr_wreq", 32'(port_write_req), 32'd0);
        step();
        idle();

        // fill the queue: five reads, fifth refused
        addr = 32'h1000_0000;
        read_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("fill_ready%0d", k), 32'(ready),
                  (k < 4) ? 32'd1 : 32'd0);
            step();
        end
        check("full_outst", 32'(outstanding), 32'd4);
        respond(0, 32'h0000_00A0);
        #1;
        check("full_pop_rdv", 32'(read_data_valid), 32'd1);
        check("full_no_bypass", 32'(ready), 32'd0);
        step();
        port_read_data_valid = 2'b00;
        #1;
        check("after_pop_outst", 32'(outstanding), 32'd3);
        check("after_pop_ready", 32'(ready), 32'd1);
        read_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            respond(0, 32'h0000_00B0 + 32'(k));
            #1;
            check($sformatf("drain_rdata%0d", k), read_data,
                  32'h0000_00B0 + 32'(k));
            step();
        end
        idle();
        #1;
        check("drain_outst", 32'(outstanding), 32'd0);

        // push and pop in the same cycle keep the count
        addr = 32'h1000_0000;
        read_req = 1'b1;
        step();
        addr = 32'h2000_0000;
        respond(0, 32'h5555_0000);
        #1;
        check("pp_rdata", read_data, 32'h5555_0000);
        step();
        idle();
        #1;
        check("pp_outst", 32'(outstanding), 32'd1);
        respond(1, 32'h6666_0000);
        #1;
        check("pp_rdata1", read_data, 32'h6666_0000);
        step();
        idle();
        #1;
        check("pp_outst0", 32'(outstanding), 32'd0);
        check("pp_no_err", 32'(order_error), 32'd0);

        // out-of-order response from port0 is dropped and flagged
        addr = 32'h2000_0000;
        read_req = 1'b1;
        step();
        addr = 32'h1000_0000;
        step();
        idle();
        respond(0, 32'h1111_1111);
        #1;
        check("ooo_rdv", 32'(read_data_valid), 32'd0);
        check("ooo_rdata", read_data, 32'd0);
        step();
        idle();
        #1;
        check("ooo_err", 32'(order_error), 32'd1);
        check("ooo_outst", 32'(outstanding), 32'd2);
        respond(1, 32'h2222_2222);
        #1;
        check("ooo_p1_rdv", 32'(read_data_valid), 32'd1);
        check("ooo_p1_rdata", read_data, 32'h2222_2222);
        step();
        idle();
        #1;
        check("ooo_outst1", 32'(outstanding), 32'd1);
        check("ooo_err_sticky", 32'(order_error), 32'd1);

        // reset with three reads in flight
        addr = 32'h1000_0000;
        read_req = 1'b1;
        step();
        step();
        idle();
        #1;
        check("pre_rst_outst", 32'(outstanding), 32'd3);
        reset_n = 1'b0;
        #1;
        check("arst_outst", 32'(outstanding), 32'd0);
        check("arst_err", 32'(order_error), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        respond(0, 32'h7777_7777);
        #1;
        check("late_rdv", 32'(read_data_valid), 32'd0);
        step();
        idle();
        #1;
        check("late_err", 32'(order_error), 32'd1);
        check("late_outst", 32'(outstanding), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
